// File: rtl/keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_if
//   Key event interface between the keypad scanner (producer) and the
//   password FSM (consumer). Both sides run in the same clk domain.
//
//   key_value  4  code of the last debounced key, stable between events
//   key_valid  1  one-cycle pulse marking a new key_value
//   key_held   1  high from the key_valid cycle until release is debounced
//
//   master : the scanner, drives all three signals
//   slave  : the consumer, samples all three signals
// ---------------------------------------------------------------------------
interface keypad_scanner_if;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_held;

    modport master (
        output key_value,
        output key_valid,
        output key_held
    );

    modport slave (
        input key_value,
        input key_valid,
        input key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces the
//   key it finds and emits one key_valid pulse per debounced press. A held
//   key never repeats; the scanner waits for a debounced release before it
//   looks for the next key.
//
// Parameters
//   SCAN_DIV      clk cycles per sample period (>= 4)
//   DEBOUNCE_CNT  consecutive identical samples needed for press and release (>= 2)
//
// Ports
//   clk      in   system clock, all logic on posedge
//   reset    in   synchronous, active-high reset
//   row_in   in   4  keypad rows, active-low, asynchronous to clk
//   col_out  out  4  column drive, active-low, exactly one bit low
//   key_bus  master modport of keypad_scanner_if (key_value/key_valid/key_held)
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                row_in,
    output logic [3:0]                col_out,
    keypad_scanner_if.master          key_bus
);

    localparam int TMR_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [1:0]       col_q,       col_d;
    logic [1:0]       row_q,       row_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [TMR_W-1:0] timer_q,     timer_d;
    logic [3:0]       rs_meta_q,   rs_meta_d;
    logic [3:0]       rs_q,        rs_d;
    logic [3:0]       key_value_q, key_value_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q,  key_held_d;

    logic             sample;
    logic             press;
    logic [1:0]       prio_row;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       col_next;

    // Keypad legend, indexed by {row, col}. '*' is reported as E (Enter)
    // and '#' as F.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Only one column is ever driven low; the drive follows the column index.
    assign col_out = ~(4'b0001 << col_q);

    assign key_bus.key_value = key_value_q;
    assign key_bus.key_valid = key_valid_q;
    assign key_bus.key_held  = key_held_q;

    // Sample strobe at the last cycle of each dwell period.
    assign sample   = (timer_q == TMR_LAST);
    assign press    = (rs_q != 4'hF);
    assign cnt_inc  = cnt_q + CNT_ONE;
    assign col_next = col_q + 2'd1;

    // When several rows read low, the lowest row index wins so that a
    // multi-key chord always resolves to the same key.
    always_comb begin
        prio_row = 2'd0;
        if (!rs_q[0]) begin
            prio_row = 2'd0;
        end else if (!rs_q[1]) begin
            prio_row = 2'd1;
        end else if (!rs_q[2]) begin
            prio_row = 2'd2;
        end else if (!rs_q[3]) begin
            prio_row = 2'd3;
        end
    end

    // Next-state logic. The timer and synchronizer run free in every state;
    // the FSM only acts on sample cycles. key_valid is registered, so the
    // pulse appears one clk after the sample that completes the debounce.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        key_value_d = key_value_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        rs_meta_d   = row_in;
        rs_d        = rs_meta_q;
        timer_d     = sample ? '0 : timer_q + 1'b1;

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (press) begin
                        row_d   = prio_row;
                        cnt_d   = CNT_ONE;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_next;
                    end
                end
            end

            DEBOUNCE: begin
                if (sample) begin
                    if (press && (prio_row == row_q)) begin
                        if (cnt_inc == CNT_DONE) begin
                            key_valid_d = 1'b1;
                            key_value_d = key_map(row_q, col_q);
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // A bounce or a different key abandons this attempt.
                        cnt_d   = '0;
                        col_d   = col_next;
                        state_d = SCAN;
                    end
                end
            end

            HELD: begin
                if (sample) begin
                    // Counts consecutive clear samples; any press restarts.
                    if (press) begin
                        cnt_d = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        key_held_d = 1'b0;
                        cnt_d      = '0;
                        col_d      = col_next;
                        state_d    = SCAN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State register with synchronous reset. The synchronizer resets to
    // "no key" so a stale low row cannot trigger right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            cnt_q       <= '0;
            timer_q     <= '0;
            rs_meta_q   <= 4'hF;
            rs_q        <= 4'hF;
            key_value_q <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            rs_meta_q   <= rs_meta_d;
            rs_q        <= rs_d;
            key_value_q <= key_value_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
//   A keypad model turns a 16-bit "pressed" mask (bit row*4+col) into row
//   levels from the driven column. Expected key codes are queued when a
//   press is issued; a forked monitor pops and compares on every key_valid.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] pressed;

    int compared   = 0;
    int mismatched = 0;
    logic [3:0] exp_q[$];

    localparam logic [3:0] COL_SEQ [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    keypad_scanner_if key_bus ();

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .row_in  (row_in),
        .col_out (col_out),
        .key_bus (key_bus)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column; a row reads low when any
    // pressed key in it sits on the column currently driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] mask);
        pressed = mask;
    endtask

    task automatic expect_key(input logic [3:0] code);
        exp_q.push_back(code);
    endtask

    task automatic monitor();
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (key_bus.key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_pulse: actual key_value=%0h required=no pulse",
                             key_bus.key_value);
                end else begin
                    e = exp_q.pop_front();
                    check_output("pulse_value", key_bus.key_value, e);
                    check_output("pulse_held", key_bus.key_held, 1);
                end
            end
        end
    endtask

    task automatic wait_held(input logic target, input int budget, input string name,
                             output int cycles);
        cycles = 0;
        while (key_bus.key_held !== target && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check_output(name, key_bus.key_held, target);
    endtask

    task automatic wait_col(input logic [3:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (col_out !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(name, col_out, target);
    endtask

    task automatic press_and_release(input logic [15:0] mask, input logic [3:0] code,
                                     input string name);
        int cyc;
        expect_key(code);
        apply_stimulus(mask);
        wait_held(1'b1, 200, {name, "_held_rise"}, cyc);
        check_output({name, "_value"}, key_bus.key_value, code);
        apply_stimulus(16'h0);
        wait_held(1'b0, 100, {name, "_held_fall"}, cyc);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int cyc;
        reset   = 1'b1;
        pressed = 16'h0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Reset state and idle scan sequence.
        check_output("rst_key_value", key_bus.key_value, 4'h0);
        check_output("rst_key_valid", key_bus.key_valid, 1'b0);
        check_output("rst_key_held", key_bus.key_held, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check_output("idle_col_out", col_out, COL_SEQ[i/4]);
            @(negedge clk);
        end

        // Stable '6' (row1/col2), then release.
        expect_key(4'h6);
        apply_stimulus(16'h1 << (1*4+2));
        wait_held(1'b1, 200, "t2_held_rise", cyc);
        check_output("t2_value", key_bus.key_value, 4'h6);
        apply_stimulus(16'h0);
        wait_held(1'b0, 100, "t2_held_fall", cyc);
        check_output("t2_release_latency_ok", (cyc >= 11 && cyc <= 14), 1'b1);
        check_output("t2_col_resume", col_out, 4'b0111);

        // '1' bouncing every sample period: no pulse, then stable.
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(i[0] ? 16'h0 : 16'h0001);
            repeat (4) @(negedge clk);
        end
        apply_stimulus(16'h0);
        repeat (20) @(negedge clk);
        check_output("t3_bounce_no_event", key_bus.key_held, 1'b0);
        press_and_release(16'h0001, 4'h1, "t3");

        // Row priority and bottom-row codes.
        press_and_release((16'h1 << 12) | (16'h1 << 8), 4'h7, "t4_chord");
        press_and_release(16'h1 << 12, 4'hE, "t4_star");
        press_and_release(16'h1 << 14, 4'hF, "t4_hash");

        // Long hold of '5', second key '9' during HELD, then '9' alone.
        expect_key(4'h5);
        apply_stimulus(16'h1 << 5);
        repeat (1000) @(negedge clk);
        check_output("t5_held_long", key_bus.key_held, 1'b1);
        apply_stimulus((16'h1 << 5) | (16'h1 << 10));
        repeat (100) @(negedge clk);
        check_output("t5_still_5", key_bus.key_value, 4'h5);
        apply_stimulus(16'h0);
        wait_held(1'b0, 100, "t5_held_fall", cyc);
        press_and_release(16'h1 << 10, 4'h9, "t5_nine");

        // Reset during DEBOUNCE with '2' (row0/col1) kept pressed.
        wait_col(4'b1011, 100, "t6_sync_col2");
        apply_stimulus(16'h1 << 1);
        wait_col(4'b1101, 100, "t6_sync_col1");
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("t6a_col_out", col_out, 4'b1110);
        check_output("t6a_key_valid", key_bus.key_valid, 1'b0);
        check_output("t6a_key_held", key_bus.key_held, 1'b0);
        reset = 1'b0;
        expect_key(4'h2);
        wait_held(1'b1, 200, "t6a_new_event", cyc);

        // Reset during HELD with '2' still pressed.
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("t6b_col_out", col_out, 4'b1110);
        check_output("t6b_key_valid", key_bus.key_valid, 1'b0);
        check_output("t6b_key_held", key_bus.key_held, 1'b0);
        check_output("t6b_key_value", key_bus.key_value, 4'h0);
        reset = 1'b0;
        expect_key(4'h2);
        wait_held(1'b1, 200, "t6b_new_event", cyc);
        apply_stimulus(16'h0);
        wait_held(1'b0, 100, "t6b_held_fall", cyc);

        repeat (10) @(negedge clk);
        check_output("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
